gray_to_rgb565_ci: RTL

//  Multi-cycle custom instruction for the OpenRISC virtual prototype. It expands packed 8-bit grayscale pixels back to RGB565.
//  The CPU pushes words of 4 gray pixels into an internal FIFO, then pops RGB565 pixel pairs (2 per pop, 2 pops per word).

---
 rtl/gray_to_rgb565_ci_pkg.sv | 52 +++++
 rtl/gray_word_fifo.sv | 63 ++++++
 rtl/gray_to_rgb565_ci.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/gray_to_rgb565_ci_pkg.sv
// Shared definitions for the gray_to_rgb565_ci custom instruction.
// Contents:
//   - op_e     : CI opcodes carried in valueB[1:0]
//   - state_e  : handshake FSM states
//   - STAT_*   : bit positions inside the STATUS response word
//   - gray_to_rgb565() : 8-bit gray to RGB565 pixel expansion
// Configuration macro: GRAY2RGB_ROUND_EN
//   defined   -> round-to-nearest with saturation per channel
//   undefined -> plain truncation (default build)
package gray_to_rgb565_ci_pkg;

  typedef enum logic [1:0] {
    OP_PUSH   = 2'd0,
    OP_POP    = 2'd1,
    OP_STATUS = 2'd2,
    OP_CLEAR  = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RESPOND = 1'b1
  } state_e;

  localparam int STAT_OVF_BIT   = 31;
  localparam int STAT_UNF_BIT   = 30;
  localparam int STAT_HALF_BIT  = 29;
  localparam int STAT_COUNT_W   = 8;

  // Replicates the gray level into R5/G6/B5. The green channel keeps one
  // more bit of the gray value than red/blue.
  function automatic logic [15:0] gray_to_rgb565(input logic [7:0] g);
`ifdef GRAY2RGB_ROUND_EN
    logic [8:0] rb_sum;
    logic [8:0] g_sum;
    logic [5:0] rb_q;
    logic [6:0] g_q;
    logic [4:0] rb5;
    logic [5:0] g6;
    rb_sum = {1'b0, g} + 9'd4;
    g_sum  = {1'b0, g} + 9'd2;
    rb_q   = rb_sum[8:3];
    g_q    = g_sum[8:2];
    // Rounding the top gray codes overshoots the channel range; clamp.
    rb5    = (rb_q > 6'd31) ? 5'd31 : rb_q[4:0];
    g6     = (g_q > 7'd63) ? 6'd63 : g_q[5:0];
    return {rb5, g6, rb5};
`else
    return {g[7:3], g[7:2], g[7:3]};
`endif
  endfunction

endpackage

// File: rtl/gray_word_fifo.sv
// Synchronous FIFO of gray pixel words.
// Ports:
//   clk_i    in  clock, all state on rising edge
//   rst_ni   in  synchronous active-low reset (empties the FIFO)
//   push_i   in  enqueue wdata_i (ignored when full)
//   pop_i    in  dequeue head (ignored when empty)
//   clear_i  in  empty the FIFO
//   wdata_i  in  word to enqueue
//   rdata_o  out current head word (valid when !empty_o)
//   full_o / empty_o / count_o  occupancy status, count 0..DEPTH
module gray_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers are AW bits wide, so DEPTH being a power of two makes the
  // wrap modulo DEPTH free.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define
  // which entries are valid, so clearing the array would only add logic.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/gray_to_rgb565_ci.sv
// Multi-cycle custom instruction: CPU pushes words of four 8-bit gray
// pixels into a FIFO, then pops RGB565 pixel pairs (two pops per word).
// Ports:
//   clock  in   system clock
//   reset  in   synchronous active-low reset
//   start  in   CI start pulse
//   valueA in   PUSH data: 4 gray pixels, byte0 first
//   valueB in   [1:0] opcode (PUSH/POP/STATUS/CLEAR)
//   ciN    in   CI number, must equal customInstructionId
//   done   out  one-cycle completion pulse
//   result out  response word, zero whenever done is low
// Configuration macro: GRAY2RGB_ROUND_EN selects rounding pixel expansion.
module gray_to_rgb565_ci
  import gray_to_rgb565_ci_pkg::*;
#(
  parameter logic [7:0] customInstructionId = 8'd0,
  parameter int         FIFO_DEPTH          = 4,
  localparam int        CW                  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic [7:0]  ciN,
  output logic        done,
  output logic [31:0] result
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] data_q, data_d;
  logic        half_q, half_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  logic          fifo_push, fifo_pop, fifo_clear;
  logic          fifo_full, fifo_empty;
  logic [31:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status_word;

  logic unused_valueb;
  assign unused_valueb = ^valueB[31:2];

  gray_word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .clear_i (fifo_clear),
    .wdata_i (data_q),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    status_word                = '0;
    status_word[STAT_OVF_BIT]  = ovf_q;
    status_word[STAT_UNF_BIT]  = unf_q;
    status_word[STAT_HALF_BIT] = half_q;
    status_word[STAT_COUNT_W-1:0] = STAT_COUNT_W'(fifo_count);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_PUSH;
      data_q  <= '0;
      half_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      half_q  <= half_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // State updates of an op take effect on the edge that leaves RESPOND, so
  // a reset sampled on that edge discards them along with the response.
  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    half_d     = half_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_clear = 1'b0;
    done       = 1'b0;
    result     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && ciN == customInstructionId) begin
          op_d    = op_e'(valueB[1:0]);
          data_d  = valueA;
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
        done    = 1'b1;
        unique case (op_q)
          OP_PUSH: begin
            if (!fifo_full) begin
              fifo_push = 1'b1;
              result    = 32'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end
          OP_POP: begin
            if (fifo_empty) begin
              unf_d = 1'b1;
            end else if (!half_q) begin
              result = {gray_to_rgb565(fifo_head[15:8]), gray_to_rgb565(fifo_head[7:0])};
              half_d = 1'b1;
            end else begin
              result   = {gray_to_rgb565(fifo_head[31:24]), gray_to_rgb565(fifo_head[23:16])};
              fifo_pop = 1'b1;
              half_d   = 1'b0;
            end
          end
          OP_STATUS: result = status_word;
          OP_CLEAR: begin
            fifo_clear = 1'b1;
            half_d     = 1'b0;
            ovf_d      = 1'b0;
            unf_d      = 1'b0;
          end
          default: ;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase

    // A reset arriving while RESPOND is active suppresses the response.
    if (!reset) begin
      done   = 1'b0;
      result = '0;
    end
  end

endmodule
